// File: rtl/mlp_conv_burst_seq.sv
`default_nettype none
// ============================================================================
// mlp_conv_burst_seq: arbitrates read/write bursts for the AXI master and
// buffers the conv datapath streams in two FIFOs.               Rev 1.0
// ============================================================================
module mlp_conv_burst_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32,
    parameter int CNT_W      = 16
) (
    input  logic                  M_AXI_ACLK,
    input  logic                  M_AXI_ARESETN,
    input  logic                  START,
    input  logic [ADDR_WIDTH-1:0] SRC_ADDR,
    input  logic [ADDR_WIDTH-1:0] DST_ADDR,
    input  logic [CNT_W-1:0]      NUM_BURSTS,
    output logic                  BUSY,
    output logic                  DONE,
    output logic                  ERR,
    output logic                  INIT_AXI_RD_TXN,
    output logic                  INIT_AXI_WR_TXN,
    output logic [ADDR_WIDTH-1:0] TARGET_AR_ADDR,
    output logic [ADDR_WIDTH-1:0] TARGET_AW_ADDR,
    input  logic [DATA_WIDTH-1:0] AXI_RDATA,
    input  logic                  AXI_RVALID_RREADY,
    output logic [DATA_WIDTH-1:0] AXI_WDATA,
    input  logic                  AXI_WVALID_WREADY,
    input  logic                  AXI_TXN_DONE,
    input  logic                  AXI_ERROR,
    output logic [DATA_WIDTH-1:0] M_TDATA,
    output logic                  M_TVALID,
    input  logic                  M_TREADY,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
    input  logic                  S_TVALID,
    output logic                  S_TREADY
);

    localparam int                    PTR_W       = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0]        c_depth     = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]        c_burst     = (PTR_W+1)'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] c_addr_step = ADDR_WIDTH'(BURST_LEN * DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_CHK, S_RD_GO, S_WR_GO, S_GUARD, S_WAIT, S_FIN
    } state_t;

    state_t state_q, state_d;
    logic   err_q, err_d;
    logic   is_wr_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q, aw_addr_q;
    logic [CNT_W-1:0]      num_q, rd_iss_q, wr_iss_q;

    // ------------------------------------------------------------------
    // Read FIFO: master beats in, datapath stream out (show-ahead head)
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rd_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_wptr_q, rd_rptr_q;
    logic [PTR_W:0]        rd_cnt_q;
    logic w_rd_full, w_rd_empty, w_rd_push, w_rd_pop, w_rd_ovf;

    assign w_rd_full  = (rd_cnt_q == c_depth);
    assign w_rd_empty = (rd_cnt_q == '0);
    assign w_rd_pop   = !w_rd_empty && M_TREADY;
    assign w_rd_push  = AXI_RVALID_RREADY && (!w_rd_full || w_rd_pop);
    assign w_rd_ovf   = AXI_RVALID_RREADY && w_rd_full && !w_rd_pop;
    assign M_TVALID   = !w_rd_empty;
    assign M_TDATA    = w_rd_empty ? '0 : rd_mem[rd_rptr_q];

    always_ff @(posedge M_AXI_ACLK) begin
        if (w_rd_push) rd_mem[rd_wptr_q] <= AXI_RDATA;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            rd_wptr_q <= '0;
            rd_rptr_q <= '0;
            rd_cnt_q  <= '0;
        end else begin
            if (w_rd_push) rd_wptr_q <= rd_wptr_q + 1'b1;
            if (w_rd_pop)  rd_rptr_q <= rd_rptr_q + 1'b1;
            if (w_rd_push && !w_rd_pop)      rd_cnt_q <= rd_cnt_q + 1'b1;
            else if (!w_rd_push && w_rd_pop) rd_cnt_q <= rd_cnt_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Write FIFO: datapath results in, master write beats out
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] wr_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_wptr_q, wr_rptr_q;
    logic [PTR_W:0]        wr_cnt_q;
    logic w_wr_full, w_wr_empty, w_wr_push, w_wr_pop, w_wr_unf;

    assign w_wr_full  = (wr_cnt_q == c_depth);
    assign w_wr_empty = (wr_cnt_q == '0);
    assign S_TREADY   = !w_wr_full;
    assign w_wr_push  = S_TVALID && !w_wr_full;
    assign w_wr_pop   = AXI_WVALID_WREADY && !w_wr_empty;
    assign w_wr_unf   = AXI_WVALID_WREADY && w_wr_empty;
    assign AXI_WDATA  = w_wr_empty ? '0 : wr_mem[wr_rptr_q];

    always_ff @(posedge M_AXI_ACLK) begin
        if (w_wr_push) wr_mem[wr_wptr_q] <= S_TDATA;
    end

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            wr_wptr_q <= '0;
            wr_rptr_q <= '0;
            wr_cnt_q  <= '0;
        end else begin
            if (w_wr_push) wr_wptr_q <= wr_wptr_q + 1'b1;
            if (w_wr_pop)  wr_rptr_q <= wr_rptr_q + 1'b1;
            if (w_wr_push && !w_wr_pop)      wr_cnt_q <= wr_cnt_q + 1'b1;
            else if (!w_wr_push && w_wr_pop) wr_cnt_q <= wr_cnt_q - 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Job control
    // ------------------------------------------------------------------
    logic           w_start_ok, w_wr_elig, w_rd_elig, w_all_done, w_txn_end;
    logic [PTR_W:0] w_rd_free;

    // FIN already reports BUSY=0, so a back-to-back START is accepted there too
    assign w_start_ok = START && (state_q == S_IDLE || state_q == S_FIN);
    assign w_rd_free  = c_depth - rd_cnt_q;
    assign w_wr_elig  = (wr_cnt_q >= c_burst) && (wr_iss_q < num_q);
    assign w_rd_elig  = (rd_iss_q < num_q) && (w_rd_free >= c_burst);
    assign w_all_done = (rd_iss_q == num_q) && (wr_iss_q == num_q);
    assign w_txn_end  = (state_q == S_WAIT) && AXI_TXN_DONE;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            is_wr_q   <= 1'b0;
            ar_addr_q <= '0;
            aw_addr_q <= '0;
            num_q     <= '0;
            rd_iss_q  <= '0;
            wr_iss_q  <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            if (state_q == S_CHK) is_wr_q <= w_wr_elig;
            if (w_start_ok) begin
                ar_addr_q <= SRC_ADDR;
                aw_addr_q <= DST_ADDR;
                num_q     <= NUM_BURSTS;
                rd_iss_q  <= '0;
                wr_iss_q  <= '0;
            end else if (w_txn_end) begin
                if (is_wr_q) begin
                    aw_addr_q <= aw_addr_q + c_addr_step;
                    wr_iss_q  <= wr_iss_q + 1'b1;
                end else begin
                    ar_addr_q <= ar_addr_q + c_addr_step;
                    rd_iss_q  <= rd_iss_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        err_d           = err_q;
        BUSY            = 1'b0;
        DONE            = 1'b0;
        INIT_AXI_RD_TXN = 1'b0;
        INIT_AXI_WR_TXN = 1'b0;

        if (w_start_ok) err_d = 1'b0;
        if (AXI_ERROR || w_rd_ovf || w_wr_unf) err_d = 1'b1;

        case (state_q)
            S_IDLE: if (w_start_ok) state_d = S_LOAD;
            S_LOAD: begin
                BUSY    = 1'b1;
                state_d = S_CHK;
            end
            // Writes first: a full write FIFO would otherwise stall the read stream
            S_CHK: begin
                BUSY = 1'b1;
                if (w_wr_elig)       state_d = S_WR_GO;
                else if (w_rd_elig)  state_d = S_RD_GO;
                else if (w_all_done) state_d = S_FIN;
            end
            S_RD_GO: begin
                BUSY            = 1'b1;
                INIT_AXI_RD_TXN = 1'b1;
                state_d         = S_GUARD;
            end
            S_WR_GO: begin
                BUSY            = 1'b1;
                INIT_AXI_WR_TXN = 1'b1;
                state_d         = S_GUARD;
            end
            S_GUARD: begin
                BUSY    = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                BUSY = 1'b1;
                if (AXI_TXN_DONE) state_d = S_CHK;
            end
            S_FIN: begin
                DONE    = 1'b1;
                state_d = w_start_ok ? S_LOAD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ERR            = err_q;
    assign TARGET_AR_ADDR = ar_addr_q;
    assign TARGET_AW_ADDR = aw_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_mlp_conv_burst_seq.sv
`default_nettype none
// ============================================================================
// tb_mlp_conv_burst_seq: directed bench with a behavioural AXI master and an
// echoing datapath.                                             Rev 1.0
// ============================================================================
module tb_mlp_conv_burst_seq;

    logic        clk;
    logic        aresetn;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] num_bursts;
    logic        busy, done, err, init_rd, init_wr;
    logic [31:0] ar_addr, aw_addr;
    logic [31:0] rdata;
    logic        rv, wv, tdone, axi_error;
    logic [31:0] wdata;
    logic [31:0] m_tdata, s_tdata;
    logic        m_tvalid, m_tready, s_tvalid, s_tready;
    logic        echo_en, pre_en;
    logic [31:0] pre_data;

    mlp_conv_burst_seq dut (
        .M_AXI_ACLK        (clk),
        .M_AXI_ARESETN     (aresetn),
        .START             (start),
        .SRC_ADDR          (src_addr),
        .DST_ADDR          (dst_addr),
        .NUM_BURSTS        (num_bursts),
        .BUSY              (busy),
        .DONE              (done),
        .ERR               (err),
        .INIT_AXI_RD_TXN   (init_rd),
        .INIT_AXI_WR_TXN   (init_wr),
        .TARGET_AR_ADDR    (ar_addr),
        .TARGET_AW_ADDR    (aw_addr),
        .AXI_RDATA         (rdata),
        .AXI_RVALID_RREADY (rv),
        .AXI_WDATA         (wdata),
        .AXI_WVALID_WREADY (wv),
        .AXI_TXN_DONE      (tdone),
        .AXI_ERROR         (axi_error),
        .M_TDATA           (m_tdata),
        .M_TVALID          (m_tvalid),
        .M_TREADY          (m_tready),
        .S_TDATA           (s_tdata),
        .S_TVALID          (s_tvalid),
        .S_TREADY          (s_tready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath: echo the read stream, or inject preload words
    assign s_tdata  = pre_en ? pre_data : m_tdata;
    assign s_tvalid = pre_en ? 1'b1 : (m_tvalid && echo_en);
    assign m_tready = echo_en && !pre_en && s_tready;

    // Behavioural master: 2-cycle latency, 16 beats, then a TXN_DONE pulse
    int          mph, mdly, mbeat;
    logic        misw;
    logic [31:0] maddr;
    initial begin
        mph = 0; mdly = 0; mbeat = 0; misw = 1'b0; maddr = '0;
        rv = 1'b0; wv = 1'b0; tdone = 1'b0; rdata = '0;
    end
    always begin
        @(posedge clk); #1;
        rv = 1'b0; wv = 1'b0; tdone = 1'b0;
        if (!aresetn) mph = 0;
        else case (mph)
            0: if (init_rd || init_wr) begin
                misw  = init_wr;
                maddr = init_wr ? aw_addr : ar_addr;
                mdly  = 2; mbeat = 0; mph = 1;
            end
            1: begin
                mdly = mdly - 1;
                if (mdly == 0) mph = 2;
            end
            2: begin
                if (misw) wv = 1'b1;
                else begin
                    rv    = 1'b1;
                    rdata = 32'hDA7A_0000 + {16'h0, maddr[15:0]} + 32'(mbeat);
                end
                mbeat = mbeat + 1;
                if (mbeat == 16) mph = 3;
            end
            default: begin
                tdone = 1'b1;
                mph   = 0;
            end
        endcase
    end

    // Monitor on the falling edge
    int          init_kind[$];
    logic [31:0] init_addr[$];
    int          init_pops[$];
    logic [31:0] mq[$], wq[$];
    int          done_cnt;
    initial done_cnt = 0;
    always @(negedge clk) begin
        if (init_rd) begin init_kind.push_back(0); init_addr.push_back(ar_addr); init_pops.push_back(mq.size()); end
        if (init_wr) begin init_kind.push_back(1); init_addr.push_back(aw_addr); init_pops.push_back(mq.size()); end
        if (m_tvalid && m_tready) mq.push_back(m_tdata);
        if (wv) wq.push_back(wdata);
        if (done) done_cnt = done_cnt + 1;
    end

    function automatic logic [31:0] mq_at(int i);
        if (i < mq.size()) return mq[i];
        return 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] wq_at(int i);
        if (i < wq.size()) return wq[i];
        return 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] kind_at(int i);
        if (i < init_kind.size()) return 32'(init_kind[i]);
        return 32'hxxxx_xxxx;
    endfunction
    function automatic logic [31:0] iaddr_at(int i);
        if (i < init_addr.size()) return init_addr[i];
        return 32'hxxxx_xxxx;
    endfunction

    int total, bad;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
        @(posedge clk); #1;
        src_addr = s; dst_addr = d; num_bursts = n; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (done) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_init(input int base, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (init_kind.size() > base) begin ok = 1'b1; break; end
        end
    endtask

    task automatic run_t1(input string p);
        int ib, mb, wb;
        bit ok;
        ib = init_kind.size(); mb = mq.size(); wb = wq.size();
        start_job(32'h1000, 32'h2000, 16'd1);
        wait_done(300, ok);
        chk({p, "_done"}, 32'(ok), 32'd1);
        chk({p, "_err"}, 32'(err), 32'd0);
        chk({p, "_ninit"}, 32'(init_kind.size() - ib), 32'd2);
        chk({p, "_kind0"}, kind_at(ib), 32'd0);
        chk({p, "_ar"}, iaddr_at(ib), 32'h1000);
        chk({p, "_kind1"}, kind_at(ib + 1), 32'd1);
        chk({p, "_aw"}, iaddr_at(ib + 1), 32'h2000);
        chk({p, "_mcnt"}, 32'(mq.size() - mb), 32'd16);
        chk({p, "_wcnt"}, 32'(wq.size() - wb), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk({p, "_mdata"}, mq_at(mb + i), 32'hDA7A_1000 + 32'(i));
            chk({p, "_wdata"}, wq_at(wb + i), 32'hDA7A_1000 + 32'(i));
        end
    endtask

    int          ib, mb, wb, db;
    bit          ok;
    logic [31:0] ra[$], wa[$];
    int          rp[$];

    initial begin
        total = 0; bad = 0;
        aresetn = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; num_bursts = '0;
        axi_error = 1'b0; echo_en = 1'b0; pre_en = 1'b0; pre_data = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_init", {30'd0, init_rd, init_wr}, 32'd0);
        chk("rst_ar", ar_addr, 32'd0);
        chk("rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("rst_sready", 32'(s_tready), 32'd1);
        @(posedge clk); #1 aresetn = 1'b1;

        // T1: single burst round trip
        echo_en = 1'b1;
        run_t1("t1");

        // T2: read stream stalled, third read held back until room frees up
        @(posedge clk); #1 echo_en = 1'b0;
        ib = init_kind.size(); mb = mq.size(); wb = wq.size();
        start_job(32'h1000, 32'h2000, 16'd3);
        repeat (120) @(negedge clk);
        chk("t2_stall_ninit", 32'(init_kind.size() - ib), 32'd2);
        chk("t2_stall_ar0", iaddr_at(ib), 32'h1000);
        chk("t2_stall_ar1", iaddr_at(ib + 1), 32'h1040);
        chk("t2_stall_busy", 32'(busy), 32'd1);
        chk("t2_stall_pops", 32'(mq.size() - mb), 32'd0);
        @(posedge clk); #1 echo_en = 1'b1;
        wait_done(800, ok);
        chk("t2_done", 32'(ok), 32'd1);
        ra.delete(); wa.delete(); rp.delete();
        for (int i = ib; i < init_kind.size(); i++) begin
            if (init_kind[i] == 0) begin ra.push_back(init_addr[i]); rp.push_back(init_pops[i]); end
            else wa.push_back(init_addr[i]);
        end
        chk("t2_nrd", 32'(ra.size()), 32'd3);
        chk("t2_nwr", 32'(wa.size()), 32'd3);
        for (int b = 0; b < 3; b++) begin
            chk("t2_ar", (b < ra.size()) ? ra[b] : 32'hxxxx_xxxx, 32'h1000 + 32'(b * 64));
            chk("t2_aw", (b < wa.size()) ? wa[b] : 32'hxxxx_xxxx, 32'h2000 + 32'(b * 64));
        end
        chk("t2_withheld", (rp.size() > 2) ? 32'(rp[2] - mb >= 16) : 32'hxxxx_xxxx, 32'd1);
        chk("t2_wcnt", 32'(wq.size() - wb), 32'd48);
        for (int b = 0; b < 3; b++)
            for (int i = 0; i < 16; i++)
                chk("t2_wdata", wq_at(wb + b * 16 + i), 32'hDA7A_1000 + 32'(b * 64 + i));

        // T3: zero-burst job
        ib = init_kind.size();
        start_job(32'h1000, 32'h2000, 16'd0);
        @(negedge clk);
        chk("t3_c1_busy", 32'(busy), 32'd1);
        chk("t3_c1_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("t3_c2_busy", 32'(busy), 32'd1);
        chk("t3_c2_done", 32'(done), 32'd0);
        @(negedge clk);
        chk("t3_c3_done", 32'(done), 32'd1);
        chk("t3_c3_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t3_c4_done", 32'(done), 32'd0);
        chk("t3_noinit", 32'(init_kind.size() - ib), 32'd0);

        // T4: preloaded results are written before the first read
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            pre_en = 1'b1; pre_data = 32'hBEEF_0000 + 32'(i);
        end
        @(posedge clk); #1 pre_en = 1'b0;
        ib = init_kind.size(); wb = wq.size();
        start_job(32'h3000, 32'h4000, 16'd1);
        wait_done(300, ok);
        chk("t4_done", 32'(ok), 32'd1);
        chk("t4_kind0", kind_at(ib), 32'd1);
        chk("t4_aw", iaddr_at(ib), 32'h4000);
        chk("t4_kind1", kind_at(ib + 1), 32'd0);
        chk("t4_ar", iaddr_at(ib + 1), 32'h3000);
        for (int i = 0; i < 16; i++)
            chk("t4_wdata", wq_at(wb + i), 32'hBEEF_0000 + 32'(i));

        // T5: master error during WAIT is sticky; leftover T4 results go out first
        ib = init_kind.size(); wb = wq.size();
        start_job(32'h5000, 32'h6000, 16'd1);
        wait_init(ib, 50, ok);
        chk("t5_init_seen", 32'(ok), 32'd1);
        repeat (3) @(posedge clk);
        #1 axi_error = 1'b1;
        @(posedge clk); #1 axi_error = 1'b0;
        @(negedge clk);
        chk("t5_err_set", 32'(err), 32'd1);
        wait_done(300, ok);
        chk("t5_done", 32'(ok), 32'd1);
        chk("t5_err_at_done", 32'(err), 32'd1);
        chk("t5_left_first", wq_at(wb), 32'hDA7A_3000);
        chk("t5_left_last", wq_at(wb + 15), 32'hDA7A_300F);

        // T6: START clears ERR; reset mid-burst abandons the job
        ib = init_kind.size();
        start_job(32'h7000, 32'h8000, 16'd1);
        @(negedge clk);
        chk("t6_err_clr", 32'(err), 32'd0);
        wait_init(ib, 50, ok);
        chk("t6_init_seen", 32'(ok), 32'd1);
        repeat (6) @(posedge clk);
        #1 aresetn = 1'b0;
        db = done_cnt;
        #1;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_init", {30'd0, init_rd, init_wr}, 32'd0);
        chk("t6_rst_ar", ar_addr, 32'd0);
        chk("t6_rst_aw", aw_addr, 32'd0);
        chk("t6_rst_mvalid", 32'(m_tvalid), 32'd0);
        chk("t6_rst_wdata", wdata, 32'd0);
        repeat (3) @(posedge clk);
        #1 aresetn = 1'b1;
        repeat (30) @(negedge clk);
        chk("t6_no_done", 32'(done_cnt - db), 32'd0);
        chk("t6_idle", 32'(busy), 32'd0);
        run_t1("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
